// File: rtl/adsr_envelope_if.sv
// Signal bundle between the synthesizer voice and the ADSR envelope block.
// The master drives the oscillator sample, the gate and the envelope settings; the slave returns the enveloped sample.
interface adsr_envelope_if;
  logic signed [10:0] audio_in;
  logic               sample_valid_in;
  logic               gate_in;
  logic [15:0]        attack_rate_in;
  logic [15:0]        decay_rate_in;
  logic [7:0]         sustain_level_in;
  logic [15:0]        release_rate_in;
  logic signed [10:0] audio_out;
  logic               valid_out;
  logic [2:0]         state_out;
  logic [15:0]        level_out;

  modport master (
    output audio_in, sample_valid_in, gate_in,
    output attack_rate_in, decay_rate_in, sustain_level_in, release_rate_in,
    input  audio_out, valid_out, state_out, level_out
  );

  modport slave (
    input  audio_in, sample_valid_in, gate_in,
    input  attack_rate_in, decay_rate_in, sustain_level_in, release_rate_in,
    output audio_out, valid_out, state_out, level_out
  );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: a 16-bit level stepped once per sample strobe.
// A two-stage multiply/shift pipeline scales the oscillator sample by that level.
module adsr_envelope (
  input  logic          clk_in,
  input  logic          rst_in,
  adsr_envelope_if.slave env
);

  // Strobe semantics: sample_valid_in is a one-cycle qualifier with no back-pressure.
  // Every strobe is accepted. valid_out repeats each accepted strobe exactly two clocks
  // later, and audio_out holds its value between pulses.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic [2:0]         state, state_nxt;
  logic [15:0]        level, level_nxt;
  logic               gate_prev;
  logic signed [27:0] product;
  logic               prod_valid;
  logic signed [10:0] audio_q;
  logic               valid_q;

  logic               strobe;
  logic               rise, fall;
  logic [15:0]        target;
  logic [16:0]        attack_sum;
  logic [16:0]        decay_diff;
  logic signed [27:0] audio_ext;
  logic signed [27:0] level_ext;

  assign strobe     = env.sample_valid_in;
  assign rise       = env.gate_in & ~gate_prev;
  assign fall       = ~env.gate_in & gate_prev;
  assign target     = {env.sustain_level_in, env.sustain_level_in};
  assign attack_sum = {1'b0, level} + {1'b0, env.attack_rate_in};
  assign decay_diff = {1'b0, level} - {1'b0, env.decay_rate_in};
  assign audio_ext  = {{17{env.audio_in[10]}}, env.audio_in};
  assign level_ext  = {12'd0, level};

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (rise) begin
      // Retrigger keeps the current level; the ramp starts on the following strobe.
      state_nxt = ST_ATTACK;
    end else if (fall && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
      state_nxt = ST_RELEASE;
    end else begin
      case (state)
        ST_IDLE: begin
          level_nxt = 16'h0000;
        end
        ST_ATTACK: begin
          if (attack_sum >= 17'h0FFFF || env.attack_rate_in == 16'h0000) begin
            level_nxt = 16'hFFFF;
            state_nxt = ST_DECAY;
          end else begin
            level_nxt = attack_sum[15:0];
          end
        end
        ST_DECAY: begin
          // decay_diff[16] set means the subtraction wrapped below zero.
          if (decay_diff[16] || env.decay_rate_in == 16'h0000 || decay_diff[15:0] <= target) begin
            level_nxt = target;
            state_nxt = ST_SUSTAIN;
          end else begin
            level_nxt = decay_diff[15:0];
          end
        end
        ST_SUSTAIN: begin
          level_nxt = target;
        end
        ST_RELEASE: begin
          if (level <= env.release_rate_in || env.release_rate_in == 16'h0000) begin
            level_nxt = 16'h0000;
            state_nxt = ST_IDLE;
          end else begin
            level_nxt = level - env.release_rate_in;
          end
        end
        default: begin
          level_nxt = 16'h0000;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= ST_IDLE;
      level      <= 16'h0000;
      gate_prev  <= 1'b0;
      product    <= 28'sd0;
      prod_valid <= 1'b0;
      audio_q    <= 11'sd0;
      valid_q    <= 1'b0;
    end else begin
      prod_valid <= strobe;
      valid_q    <= prod_valid;
      if (strobe) begin
        state     <= state_nxt;
        level     <= level_nxt;
        gate_prev <= env.gate_in;
        // The product uses the level from before this strobe's envelope step.
        product   <= audio_ext * level_ext;
      end
      if (prod_valid) begin
        audio_q <= product[26:16];
      end
    end
  end

  assign env.audio_out = audio_q;
  assign env.valid_out = valid_q;
  assign env.state_out = state;
  assign env.level_out = level;

endmodule

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_in (all state on posedge) and rst_in.
REQ-002 The ports SHALL be:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- audio_in  input  11 signed  oscillator sample from synthesizer audio_out.
- sample_valid_in  input  1  one-cycle strobe at the sample rate; qualifies audio_in and paces the envelope.
- gate_in  input  1  note-on level (1 = key held).
- attack_rate_in  input  16  level increment per sample in ATTACK.
- decay_rate_in  input  16  level decrement per sample in DECAY.
- sustain_level_in  input  8  sustain target; target = sustain_level_in*257 (0xFF -> 0xFFFF).
- release_rate_in  input  16  level decrement per sample in RELEASE.
- audio_out  output  11 signed  enveloped sample.
- valid_out  output  1  one-cycle strobe qualifying audio_out.
- state_out  output  3  current state encoding.
- level_out  output  16  current envelope level.

Function
REQ-003 The envelope level SHALL be a 16-bit unsigned register, 0x0000 (silent) to 0xFFFF (full).
REQ-004 The state machine SHALL have states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4; state_out SHALL carry this encoding.
REQ-005 State and level SHALL update only on clocks with sample_valid_in=1; otherwise they SHALL hold.
REQ-006 Gate edges SHALL be detected at strobes only: gate_prev latches gate_in on every strobe; rise = gate_in & ~gate_prev, fall = ~gate_in & gate_prev; gate pulses wholly between strobes SHALL be ignored.
REQ-007 Priority at a strobe SHALL be: rise, then fall, then the normal state step.
REQ-008 Rise from any state SHALL go to ATTACK with level unchanged (no restart from zero); the ATTACK step SHALL begin at the next strobe.
REQ-009 Fall in ATTACK, DECAY or SUSTAIN SHALL go to RELEASE with level unchanged; fall in IDLE or RELEASE SHALL have no effect.
REQ-010 IDLE step: level SHALL be forced to 0.
REQ-011 ATTACK step: level + attack_rate_in SHALL be computed in 17 bits; if the sum is >= 0xFFFF or attack_rate_in = 0, level SHALL become 0xFFFF and state SHALL become DECAY; otherwise level SHALL become the sum.
REQ-012 DECAY step: if level - decay_rate_in <= target, or decay_rate_in = 0, or the subtraction underflows, level SHALL become target and state SHALL become SUSTAIN; otherwise level SHALL become level - decay_rate_in.
REQ-013 SUSTAIN step: level SHALL be set to the current target each strobe, so sustain_level_in changes are tracked.
REQ-014 RELEASE step: if level <= release_rate_in or release_rate_in = 0, level SHALL become 0 and state SHALL become IDLE; otherwise level SHALL become level - release_rate_in.
REQ-015 Output pipeline:
- Stage 1, at a strobe: register audio_in * signed{1'b0, level} as a 28-bit signed product, using level before that strobe's update.
- Stage 2: audio_out = product[26:16], i.e. arithmetic shift right by 16.
REQ-016 valid_out SHALL pulse exactly 2 clocks after each sample_valid_in pulse; audio_out SHALL hold between pulses.
REQ-017 Back-to-back strobes on consecutive clocks SHALL be fully pipelined with no drops.

Reset
REQ-018 While rst_in=1 at a posedge, all of the following SHALL be cleared: state=IDLE, level=0, gate_prev=0, product=0, audio_out=0, valid_out=0, pipeline valid bits=0.
REQ-019 Reset mid-operation SHALL discard in-flight samples; no valid_out SHALL appear for strobes issued before or during reset.
REQ-020 Strobes coinciding with rst_in=1 SHALL be ignored.

Verification
REQ-021 Attack ramp: gate_in=1, attack_rate=0x4000, strobes every 4 clocks -> level 0x4000, 0x8000, 0xC000, then 0xFFFF with state DECAY at the 5th strobe; gate rise consumed at the 1st strobe.
REQ-022 Decay/sustain: decay_rate=0x1000, sustain=0x80 (target 0x8080), starting at 0xFFFF -> level 0xEFFF ... then clamps to 0x8080, state SUSTAIN; changing sustain to 0x40 -> level 0x4040 at the next strobe.
REQ-023 Release and retrigger:
- gate falls in SUSTAIN at 0x8080 with release_rate=0x8000 -> RELEASE, then 0x0080, then 0 with state IDLE.
- Rise while in RELEASE at 0x0080 -> ATTACK from 0x0080.
REQ-024 Scaling and latency:
- level 0xFFFF, audio_in=-1024 -> audio_out=-1024; audio_in=1023 -> audio_out=1022.
- level 0x8000, audio_in=512 -> audio_out=256.
- Each result with valid_out exactly 2 clocks after its strobe.
REQ-025 Edge cases:
- Strobes on consecutive clocks -> one valid_out per clock, in order.
- Gate pulse between strobes -> no state change.
- Rise and attack-complete in the same strobe -> rise wins.
- rst_in mid-ATTACK -> IDLE, level 0, no stale valid_out.
